output_stage: RTL and testbench
===============================

OUTPUT_STAGE -- requirements
Module: output_stage

Interface
REQ-001 Ports: one clock; reset is asynchronous and active-low; names CLK and rst_n.
REQ-002 Parameter: FIFO_DEPTH, default 16, internal word-FIFO depth; power of two, 4..64.
REQ-003 CLK  input  1  system/FT601 clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 txe_n  input  1  FT601 transmit-ready, active-low; 0 = device accepts a word at this edge.
REQ-006 data_in  input  32  capture word, valid whenever counter changes.
REQ-007 counter  input  21  capture word index; 0 = first word of a frame.
REQ-008 data  output  32  registered word driven to FT601 bus.
REQ-009 be  output  4  registered byte enables.
REQ-010 wr_n  output  1  registered write strobe, active-low.

Function
REQ-011 New-word detect: counter != counter_q, where counter_q is counter registered every cycle.
- On detect, push data_in into the FIFO in the same cycle.
REQ-012 Frame start: new-word detect with counter == 0.
REQ-013 FIFO full on detect: word dropped; FIFO contents unchanged.
- Exception: a transfer completing in the same cycle frees a slot, so the push is accepted.
REQ-014 Transfer completes at a rising edge where wr_n==0 and txe_n==0; FIFO head then popped.
REQ-015 States: IDLE, WRITE.
- IDLE: wr_n=1, be=0000.
- IDLE->WRITE when FIFO non-empty and txe_n==0; registers data=head, wr_n=0, be=1111.
REQ-016 WRITE behaviour per rising edge:
- Transfer completes and FIFO still non-empty with txe_n==0: stay WRITE, load next word (back-to-back, 1 word/clock).
- Transfer completes otherwise: return to IDLE, wr_n=1.
REQ-017 WRITE with txe_n==1 at an edge: no transfer; hold data and wr_n=0 until txe_n==0.
REQ-018 Latency: word pushed at edge N appears on data with wr_n=0 at edge N+1 at earliest (FIFO empty, txe_n=0).
REQ-019 Ordering: words leave in push order; no duplication; none lost except per REQ-013.
REQ-020 data retains last transferred value in IDLE.
REQ-021 Counter wrap 21'h1FFFFF->0: treated as a change, i.e. a frame start.

Reset
REQ-022 While rst_n==0:
- data=0, be=0000, wr_n=1, state=IDLE, FIFO empty.
- counter_q=21'h1FFFFF, so counter==0 at release counts as a new word.
REQ-023 Reset mid-transfer: outputs go to reset values immediately (asynchronous); buffered words are discarded.

Configuration
REQ-024 Macro OUTPUT_STAGE_FRAME_MARKER_EN.
- Defined: on each frame start, push marker 32'hA5A5_5A5A immediately ahead of the counter==0 word.
- The marker and the word occupy two FIFO slots, pushed atomically; if fewer than two slots are free, both are dropped.
- Undefined: no marker; only data_in words are pushed.

Verification
REQ-025 Reset hold 100 ns, txe_n=1, counter=0, data_in=0 -> data=0, be=0000, wr_n=1 throughout and after release.
REQ-026 After release, counter 0..3 with data_in 0x11..0x44, txe_n=0 -> four consecutive wr_n=0 cycles, data 0x11,0x22,0x33,0x44, be=1111, then wr_n=1.
REQ-027 txe_n=1 for 5 cycles while in WRITE with 0x22 on data -> data held at 0x22 with wr_n=0; resumes on txe_n=0 with no loss or duplicate.
REQ-028 FIFO_DEPTH=16, txe_n=1, push 20 words -> after txe_n=0, exactly the first 16 are output, in order.
REQ-029 Reset asserted during burst -> wr_n=1 and data=0 within the same cycle; no output after release until new words arrive.
REQ-030 Macro defined, frame start with data_in=0xDEAD0000 -> output 0xA5A55A5A then 0xDEAD0000; macro undefined -> only 0xDEAD0000.

Source files
------------

// File: rtl/output_stage.sv
// FT601 output stage: buffers capture words in a FIFO and streams them onto the bus.
// Define OUTPUT_STAGE_FRAME_MARKER_EN to prefix each frame-start word with a marker.
module output_stage #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        CLK,
   input  logic        rst_n,
   input  logic        txe_n,
   input  logic [31:0] data_in,
   input  logic [20:0] counter,
   output logic [31:0] data,
   output logic [3:0]  be,
   output logic        wr_n
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int AW1 = AW + 1;
   localparam logic [AW:0] DEPTH_W = AW1'(FIFO_DEPTH);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t        state;
   logic [20:0]   counter_q;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_p1;
   logic [AW:0]   count, free;
   logic          new_word, xfer;
   logic [1:0]    push_n;

   assign new_word  = counter != counter_q;
   assign xfer      = !wr_n && !txe_n;
   assign rd_ptr_p1 = rd_ptr + AW'(1);
   // a word leaving at this edge frees its slot for a word arriving at the same edge
   assign free      = DEPTH_W - count + AW1'(xfer);

`ifdef OUTPUT_STAGE_FRAME_MARKER_EN
   localparam logic [31:0] MARKER = 32'hA5A5_5A5A;
   logic          frame_start;
   logic [AW-1:0] wr_ptr_p1;

   assign frame_start = new_word && (counter == '0);
   assign wr_ptr_p1   = wr_ptr + AW'(1);

   // marker and frame-start word go in together or not at all
   always_comb begin
      push_n = 2'd0;
      if (frame_start) begin
         if (free >= AW1'(2)) push_n = 2'd2;
      end else if (new_word && free != '0) begin
         push_n = 2'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_n == 2'd2) begin
         mem[wr_ptr]    <= MARKER;
         mem[wr_ptr_p1] <= data_in;
      end else if (push_n == 2'd1) begin
         mem[wr_ptr]    <= data_in;
      end
   end
`else
   always_comb begin
      push_n = 2'd0;
      if (new_word && free != '0) push_n = 2'd1;
   end

   always_ff @(posedge CLK) begin
      if (push_n == 2'd1) mem[wr_ptr] <= data_in;
   end
`endif

   // counter_q resets to all-ones so counter==0 at release is seen as a new frame
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         counter_q <= '1;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         counter_q <= counter;
         wr_ptr    <= wr_ptr + AW'(push_n);
         rd_ptr    <= rd_ptr + AW'(xfer);
         count     <= count + AW1'(push_n) - AW1'(xfer);
      end
   end

   // data shows the FIFO head while in WRITE; the head is popped only when the word is taken
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         data  <= '0;
         be    <= '0;
         wr_n  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (count != '0 && !txe_n) begin
                  state <= WRITE;
                  data  <= mem[rd_ptr];
                  be    <= 4'b1111;
                  wr_n  <= 1'b0;
               end
            end
            WRITE: begin
               if (!txe_n) begin
                  if (count > AW1'(1)) begin
                     data <= mem[rd_ptr_p1];
                  end else begin
                     state <= IDLE;
                     be    <= 4'b0000;
                     wr_n  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               be    <= 4'b0000;
               wr_n  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_output_stage.sv
// Scoreboard bench for output_stage: occupancy-based reference model plus bus monitor.
`timescale 1ns/1ps
module tb_output_stage;

   localparam int DEPTH = 16;
   localparam logic [31:0] MARKER = 32'hA5A5_5A5A;
`ifdef OUTPUT_STAGE_FRAME_MARKER_EN
   localparam bit MARK_EN = 1'b1;
`else
   localparam bit MARK_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        rst_n, txe_n;
   logic [31:0] data_in;
   logic [20:0] counter;
   logic [31:0] data;
   logic [3:0]  be;
   logic        wr_n;

   output_stage #(.FIFO_DEPTH(DEPTH)) dut (
      .CLK(CLK), .rst_n(rst_n), .txe_n(txe_n), .data_in(data_in),
      .counter(counter), .data(data), .be(be), .wr_n(wr_n)
   );

   always #5 CLK = ~CLK;

   int          vectors = 0, miscompares = 0;
   logic [31:0] exp_q[$];
   int          occ = 0, m_xf, m_need;
   logic [20:0] prev_cnt = '1;
   logic [31:0] last_data = '0, prev_data = '0, exp_w;
   int          xfer_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // reference model: a capture word is kept when the buffer has room for it (and its marker)
   always @(negedge CLK) begin
      if (!rst_n) begin
         exp_q.delete();
         occ      = 0;
         prev_cnt = '1;
      end else begin
         m_xf = (!wr_n && !txe_n) ? 1 : 0;
         if (counter != prev_cnt) begin
            m_need = (MARK_EN && counter == 21'd0) ? 2 : 1;
            if (DEPTH - occ + m_xf >= m_need) begin
               if (m_need == 2) exp_q.push_back(MARKER);
               exp_q.push_back(data_in);
               occ += m_need;
            end
         end
         occ -= m_xf;
         prev_cnt = counter;
      end
   end

   // monitor: every word the FT601 takes must be the oldest expected one
   always @(negedge CLK) begin
      if (!rst_n) begin
         last_data = '0;
         prev_data = '0;
      end else begin
         check("be", {28'd0, be}, wr_n ? 32'h0 : 32'hF);
         if (!wr_n && !txe_n) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL spurious_xfer: got %h, expected no transfer", data);
            end else begin
               exp_w = exp_q.pop_front();
               check("xfer_data", data, exp_w);
            end
            prev_data = last_data;
            last_data = data;
         end else if (wr_n) begin
            check("idle_hold", data, last_data);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_word(input logic [20:0] c, input logic [31:0] d);
      counter = c;
      data_in = d;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, base, k, r;
      rst_n = 1'b0; txe_n = 1'b1; counter = '0; data_in = '0;
      repeat (10) begin
         @(negedge CLK);
         check("rst_data", data, 32'h0);
         check("rst_be", {28'd0, be}, 32'h0);
         check("rst_wr_n", {31'd0, wr_n}, 32'h1);
      end
      @(posedge CLK); #1;
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge CLK);
         check("post_rst_wr_n", {31'd0, wr_n}, 32'h1);
         check("post_rst_data", data, 32'h0);
      end

      // drain the word captured at release, then a frame 0..3 through the wrap
      @(posedge CLK); #1;
      txe_n = 1'b0;
      repeat (5) tick();
      push_word(21'h1FFFFF, 32'h99);
      repeat (4) tick();
      n = 0;
      fork
         for (int i = 0; i < 4; i++) push_word(21'(i), 32'h11 * (i + 1));
         repeat (10) begin
            @(negedge CLK);
            if (!wr_n) n++;
         end
      join
      check("burst_len", n, MARK_EN ? 5 : 4);

      // stall with 0x22 on the bus
      txe_n = 1'b1;
      for (int i = 0; i < 4; i++) push_word(21'(10 + i), 32'h11 * (i + 1));
      repeat (2) tick();
      txe_n = 1'b0;
      tick();
      tick();
      txe_n = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         check("stall_data", data, 32'h22);
         check("stall_wr_n", {31'd0, wr_n}, 32'h0);
      end
      @(posedge CLK); #1;
      txe_n = 1'b0;
      repeat (8) tick();

      // overflow: 20 words into a 16-deep buffer
      txe_n = 1'b1;
      base = xfer_cnt;
      for (int i = 0; i < 20; i++) push_word(21'(100 + i), 32'hC000_0000 + i);
      txe_n = 1'b0;
      repeat (40) tick();
      check("overflow_count", xfer_cnt - base, 16);

      // frame start word
      push_word(21'd7, 32'h1234_5678);
      push_word(21'd0, 32'hDEAD_0000);
      repeat (8) tick();
      check("frame_last", last_data, 32'hDEAD_0000);
      check("frame_prev", prev_data, MARK_EN ? MARKER : 32'h1234_5678);

      // randomized traffic with periodic long stalls and a counter wrap
      counter = 21'h1FFFFD;
      for (int i = 0; i < 500; i++) begin
         txe_n = ((i % 100) >= 70 && (i % 100) < 95) ? 1'b1 : ($urandom_range(0, 9) < 3);
         r = $urandom_range(0, 9);
         if (r < 5)       counter = counter + 21'd1;
         else if (r == 5) counter = '0;
         else if (r == 6) counter = 21'($urandom);
         data_in = $urandom;
         tick();
      end
      txe_n = 1'b0;
      repeat (40) tick();
      check("random_drained", exp_q.size(), 0);

      // reset in the middle of a burst
      for (int i = 0; i < 6; i++) push_word(21'(200 + i), 32'hB000_0000 + i);
      k = 0;
      while (wr_n && k < 20) begin
         tick();
         k++;
      end
      check("burst_wait", {31'd0, wr_n}, 32'h0);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_wr_n", {31'd0, wr_n}, 32'h1);
      check("rst_mid_data", data, 32'h0);
      check("rst_mid_be", {28'd0, be}, 32'h0);
      counter = 21'h1FFFFF;
      data_in = 32'h77;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge CLK);
         check("post_rst_idle", {31'd0, wr_n}, 32'h1);
      end
      @(posedge CLK); #1;
      push_word(21'd300, 32'h55AA_55AA);
      repeat (6) tick();
      check("final_last", last_data, 32'h55AA_55AA);
      check("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
